// File: rtl/fifo_sp_384x32_ctrl.sv
// Streaming FIFO controller over a single-port SRAM: reads take priority on the
// port, and a 3-entry output queue absorbs the 1-cycle SRAM read latency.
module fifo_sp_384x32_ctrl #(
  parameter int DEPTH  = 384,
  parameter int ADR_WD = 9,
  parameter int DAT_WD = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              wr_vld_i,
  input  logic [DAT_WD-1:0] wr_dat_i,
  output logic              wr_rdy_o,
  output logic              rd_vld_o,
  output logic [DAT_WD-1:0] rd_dat_o,
  input  logic              rd_rdy_i,
  output logic [8:0]        cnt_o,
  output logic [ADR_WD-1:0] ram_adr_o,
  output logic              ram_wr_ena_o,
  output logic [DAT_WD-1:0] ram_wr_dat_o,
  output logic              ram_rd_ena_o,
  input  logic [DAT_WD-1:0] ram_rd_dat_i
);
  localparam int OQ_N = 3;
  localparam int CW   = $clog2(DEPTH + 1);

  logic [ADR_WD-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]               ram_cnt;
  logic                        inflt;
  logic [1:0]                  oq_cnt;
  logic [OQ_N-1:0][DAT_WD-1:0] oq, oq_nxt;
  logic                        rd_issue, wr_acc, pop;
  logic [1:0]                  app_idx;

  function automatic logic [ADR_WD-1:0] ptr_inc(input logic [ADR_WD-1:0] p);
    return (p == ADR_WD'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Issue depends only on registered state, so it never waits on the consumer.
  assign rd_issue = (ram_cnt != '0) && ((3'(oq_cnt) + 3'(inflt)) < 3'd3) && !flush_i && !rst;
  assign wr_rdy_o = (ram_cnt < CW'(DEPTH)) && !rd_issue && !flush_i && !rst;
  assign wr_acc   = wr_vld_i && wr_rdy_o;

  assign rd_vld_o = (oq_cnt != 2'd0);
  assign rd_dat_o = oq[0];
  assign pop      = rd_vld_o && rd_rdy_i && !flush_i && !rst;

  assign ram_rd_ena_o = rd_issue;
  assign ram_wr_ena_o = wr_acc;
  assign ram_wr_dat_o = wr_dat_i;
  assign ram_adr_o    = rst ? '0 : (rd_issue ? rd_ptr : wr_ptr);

  // Head lives in oq[0]; returning data lands just behind the last survivor.
  assign app_idx = oq_cnt - 2'(pop);

  always_comb begin
    oq_nxt = oq;
    if (pop) begin
      for (int i = 0; i < OQ_N - 1; i++) oq_nxt[i] = oq[i+1];
    end
    if (inflt) begin
      for (int i = 0; i < OQ_N; i++) begin
        if (2'(i) == app_idx) oq_nxt[i] = ram_rd_dat_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
      inflt   <= 1'b0;
      oq_cnt  <= 2'd0;
      oq      <= '0;
      cnt_o   <= 9'd0;
    end else begin
      if (wr_acc) begin
        wr_ptr  <= ptr_inc(wr_ptr);
        ram_cnt <= ram_cnt + CW'(1);
      end
      if (rd_issue) begin
        rd_ptr  <= ptr_inc(rd_ptr);
        ram_cnt <= ram_cnt - CW'(1);
      end
      inflt  <= rd_issue;
      oq_cnt <= oq_cnt + 2'(inflt) - 2'(pop);
      oq     <= oq_nxt;
      // Total occupancy only moves on the external handshakes.
      cnt_o  <= cnt_o + 9'(wr_acc) - 9'(pop);
    end
  end
endmodule

// File: tb/tb_fifo_sp_384x32_ctrl.sv
// Bench for fifo_sp_384x32_ctrl: behavioural SRAM plus a queue reference model.
module tb_fifo_sp_384x32_ctrl;
  localparam int DEPTH = 384;

  logic        clk = 1'b0;
  logic        rst, flush_i, wr_vld_i, rd_rdy_i;
  logic [31:0] wr_dat_i, rd_dat_o, ram_wr_dat_o, ram_rd_dat_i;
  logic        wr_rdy_o, rd_vld_o, ram_wr_ena_o, ram_rd_ena_o;
  logic [8:0]  cnt_o, ram_adr_o;

  int n_chk = 0, n_fail = 0;

  logic [31:0] mem [DEPTH];
  logic [31:0] q[$];

  // Values sampled during the most recent tick (cycle just completed).
  logic        acc_w, acc_r, exp_ok, s_wr, s_rd, s_wrdy;
  logic [31:0] pop_dat, exp_dat;
  logic [8:0]  s_adr;

  fifo_sp_384x32_ctrl dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .wr_vld_i(wr_vld_i), .wr_dat_i(wr_dat_i), .wr_rdy_o(wr_rdy_o),
    .rd_vld_o(rd_vld_o), .rd_dat_o(rd_dat_o), .rd_rdy_i(rd_rdy_i),
    .cnt_o(cnt_o), .ram_adr_o(ram_adr_o), .ram_wr_ena_o(ram_wr_ena_o),
    .ram_wr_dat_o(ram_wr_dat_o), .ram_rd_ena_o(ram_rd_ena_o),
    .ram_rd_dat_i(ram_rd_dat_i)
  );

  always #5 clk = ~clk;

  // SRAM: garbage on the read bus when no read was issued.
  always @(posedge clk) begin
    if (ram_wr_ena_o && ram_adr_o < 9'(DEPTH)) mem[ram_adr_o] <= ram_wr_dat_o;
    if (ram_rd_ena_o && ram_adr_o < 9'(DEPTH)) ram_rd_dat_i <= mem[ram_adr_o];
    else ram_rd_dat_i <= $urandom;
  end

  // One clock: sample handshakes, advance the reference queue, return at negedge.
  task automatic tick();
    logic clr;
    logic [31:0] wd;
    #1;
    acc_w   = wr_vld_i && wr_rdy_o;
    acc_r   = rd_vld_o && rd_rdy_i && !flush_i && !rst;
    pop_dat = rd_dat_o;
    exp_ok  = (q.size() != 0);
    exp_dat = exp_ok ? q[0] : 32'h0;
    s_wr = ram_wr_ena_o; s_rd = ram_rd_ena_o; s_adr = ram_adr_o; s_wrdy = wr_rdy_o;
    clr = rst || flush_i;
    wd  = wr_dat_i;
    @(posedge clk);
    if (clr) q.delete();
    else begin
      if (acc_r && exp_ok) void'(q.pop_front());
      if (acc_w) q.push_back(wd);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; flush_i = 0; wr_vld_i = 1; rd_rdy_i = 0; wr_dat_i = $urandom;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_chk++;
      if ({s_wr, s_rd, s_wrdy} !== 3'b000 || s_adr !== 9'd0) begin
        n_fail++; $display("FAIL rst_ram: wr=%0b rd=%0b rdy=%0b adr=%0d exp all 0", s_wr, s_rd, s_wrdy, s_adr);
      end
      n_chk++;
      if (rd_vld_o !== 1'b0 || cnt_o !== 9'd0 || rd_dat_o !== 32'h0) begin
        n_fail++; $display("FAIL rst_out: vld=%0b cnt=%0d dat=%0h exp 0", rd_vld_o, cnt_o, rd_dat_o);
      end
    end
    rst = 0; wr_vld_i = 0;
    #1;
    n_chk++;
    if (wr_rdy_o !== 1'b1 || cnt_o !== 9'd0) begin
      n_fail++; $display("FAIL post_rst: rdy=%0b cnt=%0d exp rdy=1 cnt=0", wr_rdy_o, cnt_o);
    end
    tick();
  endtask

  task automatic test_latency();
    rd_rdy_i = 0; wr_vld_i = 1; wr_dat_i = 32'hDEADBEEF;
    tick();
    n_chk++;
    if (s_wr !== 1'b1 || s_rd !== 1'b0 || s_adr !== 9'd0) begin
      n_fail++; $display("FAIL lat_write: wr=%0b rd=%0b adr=%0d exp 1 0 0", s_wr, s_rd, s_adr);
    end
    wr_vld_i = 0;
    n_chk++;
    if (cnt_o !== 9'd1) begin n_fail++; $display("FAIL lat_cnt: got %0d exp 1", cnt_o); end
    tick();
    n_chk++;
    if (s_rd !== 1'b1 || s_adr !== 9'd0 || rd_vld_o !== 1'b0) begin
      n_fail++; $display("FAIL lat_issue: rd=%0b adr=%0d vld=%0b exp 1 0 0", s_rd, s_adr, rd_vld_o);
    end
    tick();
    n_chk++;
    if (rd_vld_o !== 1'b1 || rd_dat_o !== 32'hDEADBEEF || cnt_o !== 9'd1) begin
      n_fail++; $display("FAIL lat_out: vld=%0b dat=%0h cnt=%0d exp 1 deadbeef 1", rd_vld_o, rd_dat_o, cnt_o);
    end
    rd_rdy_i = 1;
    tick();
    rd_rdy_i = 0;
    n_chk++;
    if (!acc_r || pop_dat !== 32'hDEADBEEF || cnt_o !== 9'd0) begin
      n_fail++; $display("FAIL lat_pop: acc=%0b dat=%0h cnt=%0d exp 1 deadbeef 0", acc_r, pop_dat, cnt_o);
    end
  endtask

  task automatic test_fill_wrap();
    int idx, e, cyc, npush, npop, last_w;
    logic wrap_seen;
    rd_rdy_i = 0; wr_vld_i = 1; idx = 0;
    for (cyc = 0; cyc < 2000 && idx < 387; cyc++) begin
      wr_dat_i = idx; tick(); if (acc_w) idx++;
    end
    wr_vld_i = 0;
    repeat (4) tick();
    n_chk++;
    if (idx != 387 || cnt_o !== 9'd387) begin
      n_fail++; $display("FAIL fill_cnt: pushed=%0d cnt=%0d exp 387", idx, cnt_o);
    end
    wr_vld_i = 1; wr_dat_i = 32'hBAD;
    tick();
    wr_vld_i = 0;
    n_chk++;
    if (s_wrdy !== 1'b0 || s_wr !== 1'b0) begin
      n_fail++; $display("FAIL full_rdy: rdy=%0b wr=%0b exp 0", s_wrdy, s_wr);
    end
    rd_rdy_i = 1; e = 0;
    for (cyc = 0; cyc < 1000 && e < 387; cyc++) begin
      tick();
      if (acc_r) begin
        n_chk++;
        if (pop_dat !== 32'(e)) begin n_fail++; $display("FAIL drain_data: got %0d exp %0d", pop_dat, e); end
        e++;
      end
    end
    n_chk++;
    if (e != 387 || cyc > 390 || cnt_o !== 9'd0) begin
      n_fail++; $display("FAIL drain_rate: pops=%0d cycles=%0d cnt=%0d exp 387 <=390 0", e, cyc, cnt_o);
    end
    npush = 0; npop = 0; last_w = -1; wrap_seen = 0;
    for (cyc = 0; cyc < 4000 && (npush < 400 || npop < 400); cyc++) begin
      wr_vld_i = (npush < 400);
      wr_dat_i = 32'h1000_0000 + npush;
      tick();
      if (acc_w) npush++;
      if (s_wr) begin
        if (last_w == DEPTH - 1 && s_adr == 9'd0) wrap_seen = 1;
        last_w = int'(s_adr);
      end
      if (acc_r) begin
        npop++;
        n_chk++;
        if (!exp_ok || pop_dat !== exp_dat) begin
          n_fail++; $display("FAIL wrap_data: got %0h exp %0h", pop_dat, exp_dat);
        end
      end
    end
    wr_vld_i = 0; rd_rdy_i = 0;
    n_chk++;
    if (npop != 400 || wrap_seen !== 1'b1) begin
      n_fail++; $display("FAIL wrap_seen: pops=%0d wrap=%0b exp 400 1", npop, wrap_seen);
    end
  endtask

  task automatic test_mixed_random();
    int pw, pr;
    for (int c = 0; c < 10000; c++) begin
      case (c / 2500)
        0: begin pw = 85; pr = 25; end
        1: begin pw = 20; pr = 85; end
        2: begin pw = 95; pr = 95; end
        default: begin pw = 50; pr = 50; end
      endcase
      wr_vld_i = ($urandom_range(99) < pw);
      rd_rdy_i = ($urandom_range(99) < pr);
      wr_dat_i = $urandom;
      tick();
      n_chk++;
      if (s_wr && s_rd) begin n_fail++; $display("FAIL rnd_strobes: wr=1 rd=1 exp never both"); end
      if (acc_r) begin
        n_chk++;
        if (!exp_ok || pop_dat !== exp_dat) begin
          n_fail++; $display("FAIL rnd_data: got %0h exp %0h (ref nonempty=%0b)", pop_dat, exp_dat, exp_ok);
        end
      end
      n_chk++;
      if (cnt_o !== 9'(q.size())) begin
        n_fail++; $display("FAIL rnd_cnt: got %0d exp %0d", cnt_o, q.size());
      end
    end
    wr_vld_i = 0; rd_rdy_i = 0;
  endtask

  task automatic test_flush_inflight();
    int idx;
    flush_i = 1; wr_vld_i = 0; rd_rdy_i = 0;
    tick();
    flush_i = 0;
    n_chk++;
    if (cnt_o !== 9'd0 || rd_vld_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_clear: cnt=%0d vld=%0b exp 0 0", cnt_o, rd_vld_o);
    end
    wr_vld_i = 1; idx = 0;
    for (int c = 0; c < 100 && idx < 10; c++) begin
      wr_dat_i = 32'hA0 + idx; tick(); if (acc_w) idx++;
    end
    wr_vld_i = 0;
    repeat (4) tick();
    rd_rdy_i = 1;
    tick();
    n_chk++;
    if (!acc_r || pop_dat !== 32'hA0) begin n_fail++; $display("FAIL fl_pop1: acc=%0b got %0h exp a0", acc_r, pop_dat); end
    tick();
    n_chk++;
    if (!acc_r || pop_dat !== 32'hA1 || s_rd !== 1'b1) begin
      n_fail++; $display("FAIL fl_pop2: acc=%0b got %0h issue=%0b exp 1 a1 1", acc_r, pop_dat, s_rd);
    end
    rd_rdy_i = 0; flush_i = 1; wr_vld_i = 1; wr_dat_i = 32'hBAD;
    tick();
    flush_i = 0; wr_vld_i = 0;
    n_chk++;
    if (s_rd !== 1'b0 || s_wr !== 1'b0 || s_wrdy !== 1'b0) begin
      n_fail++; $display("FAIL fl_access: rd=%0b wr=%0b rdy=%0b exp 0", s_rd, s_wr, s_wrdy);
    end
    n_chk++;
    if (cnt_o !== 9'd0 || rd_vld_o !== 1'b0) begin
      n_fail++; $display("FAIL fl_after: cnt=%0d vld=%0b exp 0 0", cnt_o, rd_vld_o);
    end
    tick(); tick();
    n_chk++;
    if (rd_vld_o !== 1'b0 || cnt_o !== 9'd0) begin
      n_fail++; $display("FAIL fl_discard: vld=%0b cnt=%0d exp 0 0", rd_vld_o, cnt_o);
    end
    wr_vld_i = 1; wr_dat_i = 32'h5;
    tick();
    wr_vld_i = 0;
    n_chk++;
    if (s_wr !== 1'b1 || s_adr !== 9'd0) begin n_fail++; $display("FAIL fl_push: wr=%0b adr=%0d exp 1 0", s_wr, s_adr); end
    tick();
    n_chk++;
    if (s_rd !== 1'b1 || s_adr !== 9'd0) begin n_fail++; $display("FAIL fl_read: rd=%0b adr=%0d exp 1 0", s_rd, s_adr); end
    tick();
    n_chk++;
    if (rd_vld_o !== 1'b1 || rd_dat_o !== 32'h5) begin
      n_fail++; $display("FAIL fl_readback: vld=%0b dat=%0h exp 1 5", rd_vld_o, rd_dat_o);
    end
    rd_rdy_i = 1;
    tick();
    rd_rdy_i = 0;
  endtask

  task automatic test_full_boundary();
    int idx;
    flush_i = 1; wr_vld_i = 0; rd_rdy_i = 0;
    tick();
    flush_i = 0; wr_vld_i = 1; idx = 0;
    for (int c = 0; c < 2000 && idx < 387; c++) begin
      wr_dat_i = $urandom; tick(); if (acc_w) idx++;
    end
    wr_vld_i = 0;
    repeat (4) tick();
    n_chk++;
    if (cnt_o !== 9'd387) begin n_fail++; $display("FAIL fb_full: got %0d exp 387", cnt_o); end
    rd_rdy_i = 1;
    tick();
    rd_rdy_i = 0;
    n_chk++;
    if (!acc_r || pop_dat !== exp_dat || s_rd !== 1'b0) begin
      n_fail++; $display("FAIL fb_pop: acc=%0b got %0h exp %0h issue=%0b", acc_r, pop_dat, exp_dat, s_rd);
    end
    tick();
    n_chk++;
    if (s_rd !== 1'b1 || s_adr !== 9'd3 || s_wrdy !== 1'b0) begin
      n_fail++; $display("FAIL fb_issue: rd=%0b adr=%0d rdy=%0b exp 1 3 0", s_rd, s_adr, s_wrdy);
    end
    wr_vld_i = 1; wr_dat_i = 32'hABC;
    tick();
    wr_vld_i = 0;
    n_chk++;
    if (s_wrdy !== 1'b1 || s_wr !== 1'b1 || s_adr !== 9'd3) begin
      n_fail++; $display("FAIL fb_push: rdy=%0b wr=%0b adr=%0d exp 1 1 3", s_wrdy, s_wr, s_adr);
    end
    n_chk++;
    if (cnt_o !== 9'd387) begin n_fail++; $display("FAIL fb_refull: got %0d exp 387", cnt_o); end
    rd_rdy_i = 1;
    for (int c = 0; c < 600 && q.size() != 0; c++) begin
      tick();
      if (acc_r) begin
        n_chk++;
        if (pop_dat !== exp_dat) begin n_fail++; $display("FAIL fb_drain: got %0h exp %0h", pop_dat, exp_dat); end
      end
    end
    rd_rdy_i = 0;
    n_chk++;
    if (q.size() != 0 || cnt_o !== 9'd0) begin
      n_fail++; $display("FAIL fb_empty: ref=%0d cnt=%0d exp 0 0", q.size(), cnt_o);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_fill_wrap();
    test_mixed_random();
    test_flush_inflight();
    test_full_boundary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
